// File: rtl/ts_mux_generator_pkg.sv
// ts_pkg: shared constants, FSM state type and the TS header byte
// formatter used by the TS multiplex generator.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC     = 8'h47;
    localparam int          TS_PKT_LEN  = 188;
    localparam int          TS_HDR_LEN  = 4;
    localparam logic [12:0] NULL_PID    = 13'h1FFF;
    localparam logic [1:0]  AFC_PAYLOAD = 2'b01;

    typedef enum logic {
        ST_SEEK,
        ST_PKT
    } ts_state_t;

    // Header bytes 0..3 of a TS packet (TEI=0, priority=0, scrambling=00).
    function automatic logic [7:0] ts_hdr_byte(input logic [1:0]  k,
                                               input logic [12:0] pid,
                                               input logic        pusi,
                                               input logic [3:0]  cc);
        logic [7:0] b;
        case (k)
            2'd1:    b = {1'b0, pusi, 1'b0, pid[12:8]};
            2'd2:    b = pid[7:0];
            2'd3:    b = {2'b00, AFC_PAYLOAD, cc};
            default: b = TS_SYNC;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ts_mux_generator_if.sv
// ts_mux_generator_if: byte-serial TS output bus.
//   DATA   - TS byte
//   DCLK   - one-cycle byte strobe, DATA stable around its rising edge
//   DVALID - DATA belongs to a packet
//   PSYNC  - DATA is the sync byte of a packet
interface ts_mux_generator_if;

    logic [7:0] DATA;
    logic       DCLK;
    logic       DVALID;
    logic       PSYNC;

    modport master (output DATA, DCLK, DVALID, PSYNC);
    modport slave  (input  DATA, DCLK, DVALID, PSYNC);

endinterface

// File: rtl/ts_mux_generator_rate_ticker.sv
// ts_rate_ticker: fractional byte-rate ticker. Adds the clamped byte rate
// to an accumulator every cycle and raises tick (combinationally) in each
// cycle where the accumulator would reach CLK_KHZ.
//   CLK, RST - clock, async active-low reset
//   kBpS     - byte rate in kB/s
//   tick     - one byte slot is due this cycle
module ts_rate_ticker #(
    parameter int unsigned CLK_KHZ = 27000,
    parameter int unsigned RATE_W  = 18
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [RATE_W-1:0] kBpS,
    output logic              tick
);

    localparam int unsigned HALF = CLK_KHZ / 2;

    logic [31:0] acc;
    logic [31:0] rate;
    logic [31:0] step;
    logic [31:0] sum;

    // Clamping to half the clock rate keeps ticks at least two cycles apart,
    // which the one-cycle DCLK pulse relies on.
    always_comb begin
        rate = 32'(kBpS);
        step = (rate > HALF) ? HALF : rate;
        sum  = acc + step;
        tick = (sum >= CLK_KHZ);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc <= '0;
        end else begin
            acc <= tick ? (sum - CLK_KHZ) : sum;
        end
    end

endmodule

// File: rtl/ts_mux_generator.sv
// ts_mux_generator: rate-controlled MPEG-TS generator interleaving N_CH
// programme PIDs round-robin, with per-PID continuity counters and optional
// null-packet fill.
//   CLK, RST  - 27 MHz clock, async active-low reset
//   PID_TABLE - PID of channel i in bits [13*i+12:13*i]
//   CH_EN     - per-channel enable
//   NULL_EN   - emit null packets when no channel is enabled
//   kBpS      - output byte rate in kB/s
//   ts        - TS byte bus (DATA/DCLK/DVALID/PSYNC)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_SEEK | between packets; next tick runs the scheduler (sync or idle)
// ST_PKT  | inside a packet; next tick emits byte idx (1..187)
module ts_mux_generator
    import ts_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CLK_KHZ = 27000,
    parameter int unsigned RATE_W  = 18
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [13*N_CH-1:0]   PID_TABLE,
    input  logic [N_CH-1:0]      CH_EN,
    input  logic                 NULL_EN,
    input  logic [RATE_W-1:0]    kBpS,
    ts_mux_generator_if.master   ts
);

    localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);
    localparam logic [7:0] HDR_LEN  = 8'(TS_HDR_LEN);

    logic            tick;
    logic            tick_q;

    ts_state_t       state_q, state_d;
    logic [7:0]      idx_q,   idx_d;
    logic [12:0]     pid_q,   pid_d;
    logic [CH_W-1:0] ch_q,    ch_d;
    logic [CH_W-1:0] last_q,  last_d;
    logic            null_q,  null_d;
    logic [7:0]      data_q,  data_d;
    logic            dvalid_q, dvalid_d;
    logic            psync_q,  psync_d;
    logic            dclk_q;
    logic [3:0]      cc_q [N_CH];
    logic [3:0]      cc_d [N_CH];

    logic            found;
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] cand;
    logic [12:0]     sel_pid;

    ts_rate_ticker #(
        .CLK_KHZ (CLK_KHZ),
        .RATE_W  (RATE_W)
    ) u_ticker (
        .CLK  (CLK),
        .RST  (RST),
        .kBpS (kBpS),
        .tick (tick)
    );

    // Cyclic search starting just after the last served channel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= int'(N_CH); i++) begin
            cand = CH_W'((32'(last_q) + 32'(i)) % N_CH);
            if (!found && CH_EN[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_pid = PID_TABLE[13*sel +: 13];
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pid_d    = pid_q;
        ch_d     = ch_q;
        last_d   = last_q;
        null_d   = null_q;
        data_d   = data_q;
        dvalid_d = dvalid_q;
        psync_d  = psync_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            cc_d[i] = cc_q[i];
        end

        if (tick) begin
            case (state_q)
                ST_SEEK: begin
                    // Idle slot unless a channel or null fill claims it.
                    data_d   = 8'h00;
                    dvalid_d = 1'b0;
                    psync_d  = 1'b0;
                    if (found || NULL_EN) begin
                        state_d  = ST_PKT;
                        idx_d    = 8'd1;
                        data_d   = TS_SYNC;
                        dvalid_d = 1'b1;
                        psync_d  = 1'b1;
                        null_d   = !found;
                        if (found) begin
                            pid_d  = sel_pid;
                            ch_d   = sel;
                            last_d = sel;
                        end else begin
                            pid_d  = NULL_PID;
                        end
                    end
                end
                ST_PKT: begin
                    dvalid_d = 1'b1;
                    psync_d  = 1'b0;
                    if (idx_q < HDR_LEN) begin
                        data_d = ts_hdr_byte(idx_q[1:0], pid_q, !null_q,
                                             null_q ? 4'h0 : cc_q[ch_q]);
                    end else begin
                        data_d = null_q ? 8'hFF : (idx_q - HDR_LEN);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SEEK;
                        idx_d   = 8'd0;
                        if (!null_q) begin
                            cc_d[ch_q] = cc_q[ch_q] + 4'd1;
                        end
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_SEEK;
            idx_q    <= '0;
            pid_q    <= '0;
            ch_q     <= '0;
            last_q   <= CH_W'(N_CH - 1);
            null_q   <= 1'b0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            psync_q  <= 1'b0;
            tick_q   <= 1'b0;
            dclk_q   <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pid_q    <= pid_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
            null_q   <= null_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            psync_q  <= psync_d;
            // DCLK trails the data register by one cycle so DATA is settled
            // across the whole pulse.
            tick_q   <= tick;
            dclk_q   <= tick_q;
            for (int i = 0; i < int'(N_CH); i++) begin
                cc_q[i] <= cc_d[i];
            end
        end
    end

    assign ts.DATA   = data_q;
    assign ts.DVALID = dvalid_q;
    assign ts.PSYNC  = psync_q;
    assign ts.DCLK   = dclk_q;

endmodule

// File: tb/tb_ts_mux_generator.sv
module tb_ts_mux_generator;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [51:0] PID_TABLE = '0;
    logic [3:0]  CH_EN = '0;
    logic        NULL_EN = 1'b0;
    logic [17:0] kBpS = '0;

    int errors = 0;
    int checks = 0;

    ts_mux_generator_if ts_bus ();

    ts_mux_generator #(
        .N_CH    (4),
        .CLK_KHZ (27000),
        .RATE_W  (18)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PID_TABLE (PID_TABLE),
        .CH_EN     (CH_EN),
        .NULL_EN   (NULL_EN),
        .kBpS      (kBpS),
        .ts        (ts_bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [12:0] pid, input logic [3:0] cc,
                                            input logic nul, input int k);
        if (k == 0) return 8'h47;
        if (k == 1) return {1'b0, !nul, 1'b0, pid[12:8]};
        if (k == 2) return pid[7:0];
        if (k == 3) return {4'h1, cc};
        return nul ? 8'hFF : 8'(k - 4);
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Waits (bounded) for the next DCLK pulse and samples the bus there.
    task automatic get_byte(output logic [7:0] d, output logic v, output logic p);
        int n;
        n = 0;
        @(negedge CLK);
        while (ts_bus.DCLK !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("dclk_seen", 32'(ts_bus.DCLK), 32'd1);
        d = ts_bus.DATA;
        v = ts_bus.DVALID;
        p = ts_bus.PSYNC;
    endtask

    task automatic read_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic nul,
                            input int k0, input int k1);
        logic [7:0] d;
        logic       v, p;
        for (int k = k0; k <= k1; k++) begin
            get_byte(d, v, p);
            chk($sformatf("data pid=%0h k=%0d", pid, k), 32'(d), 32'(exp_byte(pid, cc, nul, k)));
            chk($sformatf("dvalid k=%0d", k), 32'(v), 32'd1);
            chk($sformatf("psync k=%0d", k), 32'(p), (k == 0) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       v, p;
        int         n;

        // reset values
        #2 RST = 1'b0;
        #1;
        chk("rst_data",   32'(ts_bus.DATA),   32'd0);
        chk("rst_dvalid", 32'(ts_bus.DVALID), 32'd0);
        chk("rst_psync",  32'(ts_bus.PSYNC),  32'd0);
        chk("rst_dclk",   32'(ts_bus.DCLK),   32'd0);

        // single channel at clamped rate, CC over 17 packets (wraps to 0)
        kBpS      = 18'd20000;
        CH_EN     = 4'b0001;
        PID_TABLE = {13'h103, 13'h102, 13'h101, 13'h044C};
        do_reset();
        for (int pk = 0; pk < 17; pk++) read_pkt(13'h044C, 4'(pk), 1'b0, 0, 187);

        // tick interval at clamp is exactly 2 cycles
        get_byte(d, v, p);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ts_bus.DCLK !== 1'b1 && n < 50);
        chk("tick_interval", 32'(n), 32'd2);

        // round-robin over channels 0,1,3
        CH_EN = 4'b1011;
        PID_TABLE = {13'h103, 13'h102, 13'h101, 13'h100};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            read_pkt(13'h100, 4'(r), 1'b0, 0, 187);
            read_pkt(13'h101, 4'(r), 1'b0, 0, 187);
            read_pkt(13'h103, 4'(r), 1'b0, 0, 187);
        end

        // null fill
        CH_EN   = 4'b0000;
        NULL_EN = 1'b1;
        do_reset();
        read_pkt(13'h1FFF, 4'h0, 1'b1, 0, 187);
        read_pkt(13'h1FFF, 4'h0, 1'b1, 0, 187);

        // idle slots, then scheduler retry once a channel appears
        NULL_EN = 1'b0;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            get_byte(d, v, p);
            chk("idle_dvalid", 32'(v), 32'd0);
            chk("idle_data",   32'(d), 32'd0);
            chk("idle_psync",  32'(p), 32'd0);
        end
        CH_EN = 4'b0001;
        read_pkt(13'h100, 4'h0, 1'b0, 0, 9);

        // kBpS=0 freezes the bus on byte k=9 (payload 0x05)
        kBpS = 18'd0;
        repeat (3) @(negedge CLK);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (ts_bus.DCLK === 1'b1) n++;
        end
        chk("zero_rate_dclk",   32'(n), 32'd0);
        chk("zero_rate_data",   32'(ts_bus.DATA),   32'h05);
        chk("zero_rate_dvalid", 32'(ts_bus.DVALID), 32'd1);
        kBpS = 18'd20000;
        read_pkt(13'h100, 4'h0, 1'b0, 10, 12);

        // mid-packet config changes take effect at the next sync byte
        CH_EN     = 4'b0001;
        PID_TABLE = {13'h103, 13'h102, 13'h555, 13'h044C};
        do_reset();
        read_pkt(13'h044C, 4'h0, 1'b0, 0, 49);
        CH_EN     = 4'b0010;
        PID_TABLE = {13'h103, 13'h102, 13'h555, 13'h0777};
        read_pkt(13'h044C, 4'h0, 1'b0, 50, 187);
        read_pkt(13'h555, 4'h0, 1'b0, 0, 49);
        CH_EN = 4'b0001;
        read_pkt(13'h555, 4'h0, 1'b0, 50, 187);
        read_pkt(13'h777, 4'h1, 1'b0, 0, 99);

        // reset mid-packet
        RST = 1'b0;
        #1;
        chk("midrst_data",   32'(ts_bus.DATA),   32'd0);
        chk("midrst_dvalid", 32'(ts_bus.DVALID), 32'd0);
        chk("midrst_psync",  32'(ts_bus.PSYNC),  32'd0);
        chk("midrst_dclk",   32'(ts_bus.DCLK),   32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        read_pkt(13'h777, 4'h0, 1'b0, 0, 3);

        // rate: 3200 kB/s gives 3200 strobes per 27000 cycles
        kBpS = 18'd3200;
        do_reset();
        n = 0;
        for (int c = 0; c < 27000; c++) begin
            @(negedge CLK);
            if (ts_bus.DCLK === 1'b1) n++;
        end
        chk("rate_3200", 32'((n >= 3199 && n <= 3201) ? 1 : 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ts_mux_generator.md
Name: ts_mux_generator

Overview:
Parametrised successor of the single-PID TS test generator. It produces a rate-controlled 188-byte MPEG-TS stream that interleaves N_CH programme PIDs. Each PID keeps its own continuity counter. Channels are served round-robin, and null packets (PID 0x1FFF) fill the stream when no channel is enabled. The output feeds the T2-MI packer's TS input (DATA/DCLK/DVALID) on the same 27 MHz clock domain.

Parameters:
N_CH, 4, number of programme channels (1..16)
CLK_KHZ, 27000, CLK frequency in kHz; denominator of the rate accumulator
RATE_W, 18, width of kBpS input

Ports:
CLK  input  1  system clock (27 MHz)
RST  input  1  asynchronous active-low reset
PID_TABLE  input  13*N_CH  PID of channel i in bits [13*i+12:13*i]
CH_EN  input  N_CH  per-channel enable
NULL_EN  input  1  1 = emit null packets when no channel is enabled
kBpS  input  RATE_W  output byte rate in kilobytes/s
DATA  output  8  TS byte
DCLK  output  1  byte clock: one-cycle high pulse, DATA stable around its rising edge
DVALID  output  1  high while DATA belongs to a packet
PSYNC  output  1  high with the 0x47 sync byte of each packet

Behaviour:
- Reset (RST=0, async): DATA=0, DVALID=0, PSYNC=0, DCLK=0, accumulator=0, all CC=0, byte index=0, last-served pointer=N_CH-1 (so channel 0 is considered first).
- Rate ticker:
  - step = min(kBpS, CLK_KHZ/2); each cycle acc += step.
  - If acc+step >= CLK_KHZ: tick=1 and acc <= acc+step-CLK_KHZ.
  - The clamp guarantees ticks are at least 2 cycles apart.
  - step=0: no ticks; outputs hold, and DCLK stays 0.
- Byte pipeline:
  - Tick in cycle T → DATA/DVALID/PSYNC registered at T+1; DCLK=1 during T+2 only.
- Packet start (byte index 0, on tick):
  - Scheduler picks the first channel with CH_EN=1, searching cyclically from last-served+1.
  - That channel's PID is latched, and the pointer updates to it.
  - No channel enabled and NULL_EN=1: null packet.
  - No channel enabled and NULL_EN=0: idle byte slot (DVALID=0, DATA=0, PSYNC=0, DCLK still pulses). The next tick retries the scheduler.
- Packet bytes (index k):
  - k=0: 0x47, PSYNC=1.
  - k=1: {TEI=0, PUSI=1, prio=0, PID[12:8]}.
  - k=2: PID[7:0].
  - k=3: {scr=00, afc=01, CC[3:0]}.
  - k=4..187: (k-4)[7:0].
  - Null packet: k=1 → 0x1F, k=2 → 0xFF, k=3 → 0x10, payload 0xFF, PUSI=0.
- CC: the served channel's CC increments when k=187 is emitted, wrapping 15→0. Null packets never touch CC.
- DVALID stays high for all 188 bytes of a packet; back-to-back packets have no gap.
- CH_EN/PID_TABLE/NULL_EN changes mid-packet have no effect until the next packet start; the current packet always completes with its latched PID.
- Disabling a channel keeps its CC value; re-enabling resumes from it.
- kBpS changes take effect on the next cycle (accumulator is not cleared).
- Reset mid-packet aborts immediately; after release, the first packet starts at k=0 on channel 0 (if enabled) with CC=0.

Decomposition:
- Package ts_pkg: TS_SYNC=8'h47, TS_PKT_LEN=188, TS_HDR_LEN=4, NULL_PID=13'h1FFF, AFC_PAYLOAD=2'b01.
- Sub-module ts_rate_ticker: accumulator + clamp, outputs tick; parameters CLK_KHZ, RATE_W.
- Scheduler, CC bank and byte mux stay in ts_mux_generator.

Test Plan:
- kBpS=3200, CH_EN=4'b0001, PID0=0x044C → bytes 47 44 4C 10 00 01 … B7; next packet 47 44 4C 11; 16 packets later CC wraps to 0; 3,200,000 DCLK pulses per simulated second (±1).
- CH_EN=4'b1011, PIDs 0x100/0x101/0x102/0x103 → packet PID order 100,101,103,100,101,103…; each PID's CC increments by 1 per own packet.
- CH_EN=0, NULL_EN=1 → 47 1F FF 10 FF…FF, PSYNC once per 188 bytes; NULL_EN=0 → DVALID stays 0 while DCLK keeps pulsing.
- kBpS=20000 (>13500) → tick interval exactly 2 cycles; kBpS=0 → no DCLK pulses, outputs hold.
- Toggle CH_EN and PID0 at k=50 → current packet finishes with old PID; the change is seen at the next 0x47.
- Assert RST at k=100 → all outputs 0 asynchronously; after release, first byte is 0x47 of channel 0 with CC=0.
